div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencer for the shared iterative divider in the execute stage. It accepts one div.w, mod.w, div.wu or mod.wu operation at a time from EX through a valid/ready handshake. It runs a fixed-latency radix-2 restoring division, applies sign correction, and holds the 32-bit result until EX consumes it. It supports cancellation by pipeline flush. Mul ops and single-cycle ALU ops never enter this block.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  EX holds a valid divide op.
- req_op  in  4  one-hot {div_w, mod_w, div_wu, mod_wu}; equals new_alu_op[15:12] of the ds_to_es bus.
- req_src1  in  32  dividend (alu_src1).
- req_src2  in  32  divisor (alu_src2).
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  result available.
- resp_data  out  32  quotient or remainder, registered.
- resp_ready  in  1  EX consumes the result.
- flush  in  1  cancels any in-flight op.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: waits for a request.
  - PREP: takes absolute values of signed operands; clears remainder and count.
  - CALC: 32 iterations, one quotient bit per cycle, MSB first; a 6-bit counter tracks progress.
  - FIX: sign correction and result select.
  - DONE: holds the result.
- Transitions:
  - IDLE→PREP on req_valid & req_ready & ~flush. Operands and op are latched on that edge.
  - PREP→CALC always.
  - CALC→FIX when the iteration count reaches 31.
  - FIX→DONE always.
  - DONE→IDLE on resp_valid & resp_ready.
  - flush=1 in any state: the next state is IDLE, no response is produced, and the latched data is don't-care.
- Signed ops:
  - The quotient is negated iff the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No trap.
- Divisor == 0, any op: quotient 0xFFFFFFFF and remainder = the original dividend. The sign fix is bypassed.
- Unsigned ops: no abs and no sign fix.
- The remainder register is 33 bits, so the trial subtract does not overflow.
- If req_op is not one-hot it is accepted anyway; the result is undefined but the FSM timing is unchanged.

## Timing
- Reset values:
  - state=IDLE
  - req_ready=1
  - resp_valid=0
  - resp_data=0
  - busy=0
  - counter=0
- Fixed latency: with acceptance on edge E0, the state is PREP after E0, CALC after E1 through E32, and FIX after E33. resp_valid is first high after edge E34.
- resp_valid and resp_data stay stable until the handshake. After the handshake edge, req_ready is high in the next cycle; there is no back-to-back accept in the same cycle.
- req_ready is combinational from state only; it never depends on req_valid.
- flush and req_valid in the same IDLE cycle: flush wins and nothing is accepted.
- flush and resp_ready in the same DONE cycle: the result is dropped and the state goes to IDLE. The two cases are indistinguishable to EX.
- resetn low mid-operation: outputs go to their reset values immediately, without waiting for clk.

## Structure
- Package div_ctrl_pkg holds:
  - the state enum (IDLE, PREP, CALC, FIX, DONE; 3-bit encoding)
  - localparams for the req_op bit indices (OP_DIV_W=3, OP_MOD_W=2, OP_DIV_WU=1, OP_MOD_WU=0)
  - ITER_LAST=31
- One sub-module, div_step (combinational):
  - inputs: 33-bit partial remainder, next dividend bit, 32-bit divisor
  - outputs: new remainder and quotient bit
  - instantiated once in div_ctrl; the FSM, counter, sign logic and handshake stay in div_ctrl.

## Test plan
- div_w 100 / 7 → resp_data 14 (0x0000000E), with resp_valid first high exactly 34 edges after acceptance. mod_w -100 % 7 → 0xFFFFFFFE.
- div_w 0x80000000 / 0xFFFFFFFF → 0x80000000; mod_w on the same operands → 0. div_wu 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- div_wu 1234 / 0 → 0xFFFFFFFF; mod_w -5 % 0 → 0xFFFFFFFB.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid and resp_data are stable throughout. Raise resp_ready → IDLE next cycle, req_ready=1.
- flush at CALC iteration 10 → IDLE next edge with no resp_valid. An immediate new request div_wu 9 / 3 completes with 3 at full latency.
- Deassert resetn mid-CALC (asynchronously, between edges) → busy=0, resp_valid=0 and req_ready=1 with no clock edge. After release, a normal op completes correctly.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative divider sequencer.
// Holds the FSM state encoding, req_op bit positions and the last iteration index.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int OP_DIV_W  = 3;
  localparam int OP_MOD_W  = 2;
  localparam int OP_DIV_WU = 1;
  localparam int OP_MOD_WU = 0;

  localparam logic [5:0] ITER_LAST = 6'd31;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
// The 34-bit difference exposes the borrow, which decides the quotient bit.
module div_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] dsr_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i[31:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, dsr_i};
    q_o     = ~diff[33];
    rem_o   = q_o ? diff[32:0] : shifted;
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared 32-bit iterative divider (div.w/mod.w/div.wu/mod.wu).
// Fixed 34-edge latency from accept to resp_valid; flush returns to IDLE from any state.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// PREP  | absolute values taken, remainder and counter cleared
// CALC  | one quotient bit per cycle, MSB first, 32 cycles
// FIX   | sign correction, divide-by-zero handling, result select
// DONE  | result held until EX consumes it
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  input  logic            resp_ready,
  input  logic            flush,
  output logic            busy
);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic [32:0] step_rem;
  logic        step_q;
  logic        signed_op;
  logic        is_div;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_result;

  div_step u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[31]),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid) state_d = PREP;
        PREP:    state_d = CALC;
        CALC:    if (cnt_q == ITER_LAST) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (resp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    resp_valid = (state_q == DONE);
    resp_data  = res_q;
  end

  // The dividend register doubles as the quotient: bits shift out MSB first, quotient bits shift in.
  always_comb begin
    signed_op = op_q[OP_DIV_W] | op_q[OP_MOD_W];
    is_div    = op_q[OP_DIV_W] | op_q[OP_DIV_WU];
    quo_fix   = (signed_op && (src1_q[31] ^ src2_q[31])) ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix   = (signed_op && src1_q[31]) ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    if (src2_q == 32'd0) begin
      fix_result = is_div ? 32'hFFFF_FFFF : src1_q;
    end else begin
      fix_result = is_div ? quo_fix : rem_fix;
    end
  end

  always_comb begin
    op_d   = op_q;
    src1_d = src1_q;
    src2_d = src2_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          op_d   = req_op;
          src1_d = req_src1;
          src2_d = req_src2;
        end
      end
      PREP: begin
        dvd_d = signed_op ? abs32(src1_q) : src1_q;
        dsr_d = signed_op ? abs32(src2_q) : src2_q;
        rem_d = '0;
        cnt_d = '0;
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[30:0], step_q};
        cnt_d = cnt_q + 6'd1;
      end
      FIX: begin
        if (!flush) res_d = fix_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      op_q   <= op_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: transaction-level reference model checked every cycle,
// plus directed operations with hand-computed results and latency.
module tb_div_ctrl;

  localparam logic [3:0] DIV_W  = 4'b1000;
  localparam logic [3:0] MOD_W  = 4'b0100;
  localparam logic [3:0] DIV_WU = 4'b0010;
  localparam logic [3:0] MOD_WU = 4'b0001;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        flush;
  logic        busy;

  int checks;
  int errors;

  div_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .flush      (flush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for the four ops, straight from the division rules.
  function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa;
    int  sb;
    bit  is_signed;
    bit  is_div;
    is_signed = op[3] | op[2];
    is_div    = op[3] | op[1];
    sa = a;
    sb = b;
    if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
    if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_div ? 32'h8000_0000 : 32'd0;
      return is_div ? (sa / sb) : (sa % sb);
    end
    return is_div ? (a / b) : (a % b);
  endfunction

  // Transaction model: idle, or an op of a given age that becomes visible 34 edges after accept.
  bit          m_busy;
  bit          m_valid;
  int          m_age;
  logic [31:0] m_exp;
  logic [31:0] m_data;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy  = 0;
      m_valid = 0;
      m_age   = 0;
      m_data  = 32'd0;
    end else if (!m_busy) begin
      if (req_valid && !flush) begin
        m_busy = 1;
        m_age  = 0;
        m_exp  = ref_div(req_op, req_src1, req_src2);
      end
    end else if (flush) begin
      m_busy  = 0;
      m_valid = 0;
    end else if (m_valid) begin
      if (resp_ready) begin
        m_busy  = 0;
        m_valid = 0;
      end
    end else begin
      m_age++;
      if (m_age == 34) begin
        m_valid = 1;
        m_data  = m_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("m_req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
      chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("m_resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
      if (m_valid) chk("m_resp_data", resp_data, m_data);
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_latency"}, n, 34);
    chk({name, "_data"}, resp_data, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({name, "_hold_data"}, resp_data, exp);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_src1 = 32'd0; req_src2 = 32'd0;
    resp_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("div_100_7", DIV_W, 32'd100, 32'd7, 32'h0000_000E, 0);
    run_op("mod_m100_7", MOD_W, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("div_min_m1", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("mod_min_m1", MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("divu_max_2", DIV_WU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0);
    run_op("divu_by0", DIV_WU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("mod_m5_by0", MOD_W, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run_op("modu_1000_7", MOD_WU, 32'd1000, 32'd7, 32'd6, 0);
    run_op("div_m7_2", DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("backpressure", DIV_W, 32'd77, 32'hFFFF_FFF5, 32'hFFFF_FFF9, 5);

    // flush and req_valid together in IDLE: nothing accepted
    req_op = DIV_W; req_src1 = 32'd10; req_src2 = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);

    // flush at CALC iteration 10
    req_op = DIV_W; req_src1 = 32'd500; req_src2 = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    chk("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    run_op("divu_9_3", DIV_WU, 32'd9, 32'd3, 32'd3, 0);

    // asynchronous reset mid-CALC
    req_op = DIV_WU; req_src1 = 32'd400; req_src2 = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_data", resp_data, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", DIV_W, 32'hFFFF_FC18, 32'd10, 32'hFFFF_FF9C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
